// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit geometry, add-3 adjust constants, FSM encoding and a
// constant-width helper used to size the bit counter.
package bin2bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift correction for double dabble: a digit of
// 5 or more gets 3 added so that the following left shift carries
// correctly into the next decimal digit. The result never exceeds 12,
// so it always fits in four bits.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Conditional add-3 on one digit.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      digit_out = digit_in + BCD_DIGIT_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit
// per clock. A start in IDLE captures the number; WIDTH shift edges
// later the packed BCD result and overflow flag are published together
// with a one-cycle done pulse. The published result holds until the
// next conversion completes. Overflow is the sticky OR of every bit
// shifted out of the top digit, i.e. set whenever number >= 10**DIGITS;
// the low DIGITS decimal digits are still delivered in that case.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              number,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic               ovf_scratch;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_next;
  logic [WIDTH-1:0]   shift_next;
  logic               ovf_next;

  // One add-3 corrector per BCD digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next shift step: adjusted digits and binary shift register move left
  // as one long word; the bit falling off the top digit feeds overflow.
  always_comb begin
    scratch_next = {adj[BCD_W-2:0], shift_reg[WIDTH-1]};
    shift_next   = shift_reg << 1;
    ovf_next     = ovf_scratch | adj[BCD_W-1];
  end

  // Control FSM with working registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      ovf_scratch <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg   <= number;
            scratch     <= '0;
            ovf_scratch <= 1'b0;
            cnt         <= CNT_W'(WIDTH);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg   <= shift_next;
          scratch     <= scratch_next;
          ovf_scratch <= ovf_next;
          cnt         <= cnt - CNT_W'(1);
          // Last bit: publish the finished value straight from the
          // combinational next-step so no extra cycle is spent.
          if (cnt == CNT_W'(1)) begin
            bcd      <= scratch_next;
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq with three parameterisations:
// (8,3) main instance, (14,4) wide instance, (8,2) overflow instance.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start0, start1, start2;
  logic [7:0]  number0;
  logic [13:0] number1;
  logic [7:0]  number2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [11:0] bcd0;
  logic [15:0] bcd1;
  logic [7:0]  bcd2;
  logic        overflow0, overflow1, overflow2;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .number(number0),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(overflow0));

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .number(number1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(overflow1));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .number(number2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2));

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop and compare on done, otherwise the result must hold.
  exp_t e0, e1, e2;
  logic [11:0] last0 = '0;
  logic [15:0] last1 = '0;
  logic [7:0]  last2 = '0;

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      last0 = '0;
    end else if (done0) begin
      if (q0.size() == 0) flag("u0_unexpected_done");
      else begin
        e0 = q0.pop_front();
        cmp("u0_bcd", 32'(bcd0), 32'(e0.bcd[11:0]));
        cmp("u0_ovf", 32'(overflow0), 32'(e0.ovf));
        cmp("u0_latency", 32'(cyc), 32'(e0.cyc));
        cmp("u0_busy_at_done", 32'(busy0), 32'd0);
      end
      last0 = bcd0;
    end else begin
      cmp("u0_hold", 32'(bcd0), 32'(last0));
    end
  end

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      last1 = '0;
    end else if (done1) begin
      if (q1.size() == 0) flag("u1_unexpected_done");
      else begin
        e1 = q1.pop_front();
        cmp("u1_bcd", 32'(bcd1), 32'(e1.bcd));
        cmp("u1_ovf", 32'(overflow1), 32'(e1.ovf));
        cmp("u1_latency", 32'(cyc), 32'(e1.cyc));
      end
      last1 = bcd1;
    end else begin
      cmp("u1_hold", 32'(bcd1), 32'(last1));
    end
  end

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      last2 = '0;
    end else if (done2) begin
      if (q2.size() == 0) flag("u2_unexpected_done");
      else begin
        e2 = q2.pop_front();
        cmp("u2_bcd", 32'(bcd2), 32'(e2.bcd[7:0]));
        cmp("u2_ovf", 32'(overflow2), 32'(e2.ovf));
        cmp("u2_latency", 32'(cyc), 32'(e2.cyc));
      end
      last2 = bcd2;
    end else begin
      cmp("u2_hold", 32'(bcd2), 32'(last2));
    end
  end

  function automatic logic busy_of(input int inst);
    case (inst)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Issue one conversion; called just after a rising edge. Returns just
  // after the accepting edge with start dropped.
  task automatic issue(input int inst, input int num, input logic [15:0] eb, input logic eo);
    int n;
    exp_t e;
    n = 0;
    while (busy_of(inst) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) flag($sformatf("idle_timeout_inst%0d", inst));
    e.bcd = eb;
    e.ovf = eo;
    case (inst)
      0: begin number0 = num[7:0];  start0 = 1'b1; e.cyc = cyc + 1 + 8;  q0.push_back(e); end
      1: begin number1 = num[13:0]; start1 = 1'b1; e.cyc = cyc + 1 + 14; q1.push_back(e); end
      default: begin number2 = num[7:0]; start2 = 1'b1; e.cyc = cyc + 1 + 8; q2.push_back(e); end
    endcase
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) flag("u0_idle_timeout");
  endtask

  initial begin
    exp_t e;
    int n;
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    number0 = '0; number1 = '0; number2 = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_busy", 32'(busy0), 32'd0);
    cmp("reset_done", 32'(done0), 32'd0);
    cmp("reset_bcd", 32'(bcd0), 32'd0);
    cmp("reset_ovf", 32'(overflow0), 32'd0);
    cmp("reset_bcd_u1", 32'(bcd1), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic conversion and busy from the cycle after accept.
    issue(0, 21, 16'h021, 1'b0);
    cmp("busy_after_accept", 32'(busy0), 32'd1);
    wait_idle0();

    issue(0, 0, 16'h000, 1'b0);
    issue(0, 255, 16'h255, 1'b0);
    wait_idle0();
    @(posedge clk); #1;

    // Back-to-back with start held high; number changes while busy.
    number0 = 8'd16;
    start0 = 1'b1;
    e.bcd = 16'h016; e.ovf = 1'b0; e.cyc = cyc + 9;
    q0.push_back(e);
    @(posedge clk); #1;
    number0 = 8'd23;
    e.bcd = 16'h023; e.ovf = 1'b0; e.cyc = cyc + 17;
    q0.push_back(e);
    repeat (9) @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_idle0();
    @(posedge clk); #1;

    // Start pulse during a busy conversion is ignored.
    issue(0, 255, 16'h255, 1'b0);
    wait_idle0();
    issue(0, 100, 16'h100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    number0 = 8'd7;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_idle0();
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-conversion aborts immediately.
    issue(0, 200, 16'h200, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    q0.delete();
    cmp("abort_busy", 32'(busy0), 32'd0);
    cmp("abort_done", 32'(done0), 32'd0);
    cmp("abort_bcd", 32'(bcd0), 32'd0);
    cmp("abort_ovf", 32'(overflow0), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 42, 16'h042, 1'b0);
    wait_idle0();

    // Wide and narrow parameterisations.
    issue(1, 9999, 16'h9999, 1'b0);
    issue(1, 10000, 16'h0000, 1'b1);
    issue(2, 123, 16'h0023, 1'b1);
    issue(2, 99, 16'h0099, 1'b0);
    issue(2, 100, 16'h0000, 1'b1);

    // Drain the scoreboards, then watch for stray done pulses.
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (20) @(posedge clk);
    #1;
    cmp("scoreboard_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
